// File: rtl/hazard_id_ex_stage.sv
// ID/EX pipeline register with load-use / branch-operand hazard detection and stall sequencing.
// Latency: 1 cycle ID->EX; pc_write/if_id_write are combinational; flush overrides any stall.
module hazard_id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       id_instruction,
  input  logic [7:0]        id_ctrl,
  input  logic              id_regdst,
  input  logic [DATA_W-1:0] id_read_data1,
  input  logic [DATA_W-1:0] id_read_data2,
  input  logic [DATA_W-1:0] id_sign_ext,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic              ex_mem_memread,
  input  logic [4:0]        ex_mem_rd,
  input  logic              flush,
  output logic [4:0]        ID_EX_RegisterRs,
  output logic [4:0]        ID_EX_RegisterRt,
  output logic [4:0]        ID_EX_RegisterRd,
  output logic              ID_EX_RegWrite,
  output logic              ID_EX_MemRead,
  output logic [7:0]        ex_ctrl,
  output logic [DATA_W-1:0] ex_read_data1,
  output logic [DATA_W-1:0] ex_read_data2,
  output logic [DATA_W-1:0] ex_sign_ext,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic              pc_write,
  output logic              if_id_write,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t state;
  logic   hold_cnt;

  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_branch;
  logic       h1, h2, h3, h4;
  logic       stall;
  logic       unused_bits;

  assign id_rs     = id_instruction[25:21];
  assign id_rt     = id_instruction[20:16];
  assign id_rd     = id_instruction[15:11];
  assign id_branch = id_ctrl[3];
  assign unused_bits = ^{id_instruction[31:26], id_instruction[10:0]};

  function automatic logic src_match(input logic [4:0] dst, input logic [4:0] a,
                                     input logic [4:0] b);
    return (dst != 5'd0) && ((dst == a) || (dst == b));
  endfunction

  assign h1 = ID_EX_MemRead && src_match(ID_EX_RegisterRd, id_rs, id_rt);
  assign h2 = id_branch && ID_EX_RegWrite && !ID_EX_MemRead &&
              src_match(ID_EX_RegisterRd, id_rs, id_rt);
  assign h3 = id_branch && ID_EX_MemRead && src_match(ID_EX_RegisterRd, id_rs, id_rt);
  assign h4 = id_branch && ex_mem_memread && src_match(ex_mem_rd, id_rs, id_rt);

  // The second bubble of a branch-after-load comes from HOLD alone, whatever ex_mem_* shows.
  assign stall = ((state == HOLD) && hold_cnt) ? 1'b1 : (h1 | h2 | h3 | h4);

  assign pc_write    = flush | ~stall;
  assign if_id_write = flush | ~stall;

  assign ID_EX_RegWrite = ex_ctrl[7];
  assign ID_EX_MemRead  = ex_ctrl[6];

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= RUN;
      hold_cnt         <= 1'b0;
      stall_cycles     <= '0;
      ex_ctrl          <= '0;
      ID_EX_RegisterRs <= '0;
      ID_EX_RegisterRt <= '0;
      ID_EX_RegisterRd <= '0;
      ex_read_data1    <= '0;
      ex_read_data2    <= '0;
      ex_sign_ext      <= '0;
      ex_pc_plus4      <= '0;
    end else begin
      if (flush || stall) begin
        ex_ctrl          <= '0;
        ID_EX_RegisterRs <= '0;
        ID_EX_RegisterRt <= '0;
        ID_EX_RegisterRd <= '0;
        ex_read_data1    <= '0;
        ex_read_data2    <= '0;
        ex_sign_ext      <= '0;
        ex_pc_plus4      <= '0;
      end else begin
        ex_ctrl          <= id_ctrl;
        ID_EX_RegisterRs <= id_rs;
        ID_EX_RegisterRt <= id_rt;
        ID_EX_RegisterRd <= id_regdst ? id_rd : id_rt;
        ex_read_data1    <= id_read_data1;
        ex_read_data2    <= id_read_data2;
        ex_sign_ext      <= id_sign_ext;
        ex_pc_plus4      <= id_pc_plus4;
      end

      if (flush || (state == HOLD)) begin
        state    <= RUN;
        hold_cnt <= 1'b0;
      end else if (h3) begin
        state    <= HOLD;
        hold_cnt <= 1'b1;
      end

      if (!flush && stall && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_id_ex_stage.sv
// Directed bench for hazard_id_ex_stage: load-use, branch hazards, $0, flush in HOLD,
// reset during HOLD and stall counter saturation.
module tb_hazard_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  localparam logic [7:0] C_LW  = 8'hD4;
  localparam logic [7:0] C_ADD = 8'h82;
  localparam logic [7:0] C_BEQ = 8'h09;

  logic              clk;
  logic              rst;
  logic [31:0]       id_instruction;
  logic [7:0]        id_ctrl;
  logic              id_regdst;
  logic [DATA_W-1:0] id_read_data1, id_read_data2, id_sign_ext, id_pc_plus4;
  logic              ex_mem_memread;
  logic [4:0]        ex_mem_rd;
  logic              flush;
  logic [4:0]        ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd;
  logic              ID_EX_RegWrite, ID_EX_MemRead;
  logic [7:0]        ex_ctrl;
  logic [DATA_W-1:0] ex_read_data1, ex_read_data2, ex_sign_ext, ex_pc_plus4;
  logic              pc_write, if_id_write;
  logic [CNT_W-1:0]  stall_cycles;

  int n_assert = 0;
  int n_fail   = 0;

  hazard_id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_instruction(id_instruction), .id_ctrl(id_ctrl), .id_regdst(id_regdst),
    .id_read_data1(id_read_data1), .id_read_data2(id_read_data2),
    .id_sign_ext(id_sign_ext), .id_pc_plus4(id_pc_plus4),
    .ex_mem_memread(ex_mem_memread), .ex_mem_rd(ex_mem_rd), .flush(flush),
    .ID_EX_RegisterRs(ID_EX_RegisterRs), .ID_EX_RegisterRt(ID_EX_RegisterRt),
    .ID_EX_RegisterRd(ID_EX_RegisterRd), .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_MemRead(ID_EX_MemRead), .ex_ctrl(ex_ctrl),
    .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2),
    .ex_sign_ext(ex_sign_ext), .ex_pc_plus4(ex_pc_plus4),
    .pc_write(pc_write), .if_id_write(if_id_write), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 11'h020};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic drive(input logic [31:0] instr, input logic [7:0] ctrl, input logic regdst,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] se, input logic [31:0] pc);
    id_instruction = instr;
    id_ctrl        = ctrl;
    id_regdst      = regdst;
    id_read_data1  = d1;
    id_read_data2  = d2;
    id_sign_ext    = se;
    id_pc_plus4    = pc;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_mem_memread = 1'b0; ex_mem_rd = 5'd0;
    drive(32'h0, 8'h0, 1'b0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_ex_ctrl", ex_ctrl, 0);
    chk("reset_rd", ID_EX_RegisterRd, 0);
    chk("reset_data1", ex_read_data1, 0);
    chk("reset_stall_cycles", stall_cycles, 0);
    chk("reset_pc_write", pc_write, 1);
    chk("reset_if_id_write", if_id_write, 1);

    // Load-use: lw $8 then add $9,$8,$10
    drive(i_type(6'h23, 5'd2, 5'd8, 16'h0010), C_LW, 1'b0, 32'h11, 32'h22, 32'h10, 32'h4);
    tick();
    chk("lw_rd", ID_EX_RegisterRd, 8);
    chk("lw_memread", ID_EX_MemRead, 1);
    chk("lw_regwrite", ID_EX_RegWrite, 1);
    chk("lw_sign_ext", ex_sign_ext, 32'h10);
    chk("lw_pc_plus4", ex_pc_plus4, 32'h4);
    drive(r_type(5'd8, 5'd10, 5'd9), C_ADD, 1'b1, 32'h100, 32'h200, 32'h4820, 32'h8);
    chk("lu_pc_write", pc_write, 0);
    chk("lu_if_id_write", if_id_write, 0);
    tick();
    chk("lu_bubble_ctrl", ex_ctrl, 0);
    chk("lu_bubble_rs", ID_EX_RegisterRs, 0);
    chk("lu_bubble_data2", ex_read_data2, 0);
    chk("lu_stall_cycles", stall_cycles, 1);
    #1;
    chk("lu_release_pc_write", pc_write, 1);
    tick();
    chk("lu_add_rs", ID_EX_RegisterRs, 8);
    chk("lu_add_rt", ID_EX_RegisterRt, 10);
    chk("lu_add_rd", ID_EX_RegisterRd, 9);
    chk("lu_add_ctrl", ex_ctrl, C_ADD);
    chk("lu_add_data2", ex_read_data2, 32'h200);
    chk("lu_stall_hold", stall_cycles, 1);

    // Branch after ALU op: add $5 then beq $5,$6
    drive(r_type(5'd1, 5'd2, 5'd5), C_ADD, 1'b1, 32'h1, 32'h2, 32'h0, 32'hC);
    chk("add5_no_stall", pc_write, 1);
    tick();
    chk("add5_rd", ID_EX_RegisterRd, 5);
    drive(i_type(6'h04, 5'd5, 5'd6, 16'h0003), C_BEQ, 1'b0, 32'h5, 32'h6, 32'h3, 32'h10);
    chk("h2_pc_write", pc_write, 0);
    tick();
    chk("h2_bubble_ctrl", ex_ctrl, 0);
    chk("h2_stall_cycles", stall_cycles, 2);
    #1;
    chk("h2_release", pc_write, 1);
    tick();
    chk("h2_beq_branch", ex_ctrl[3], 1);
    chk("h2_beq_rd_is_rt", ID_EX_RegisterRd, 6);
    chk("h2_stall_hold", stall_cycles, 2);

    // Branch after load: two bubbles, second from HOLD with ex_mem_memread low
    drive(i_type(6'h23, 5'd3, 5'd5, 16'h0), C_LW, 1'b0, 32'h0, 32'h0, 32'h0, 32'h14);
    tick();
    chk("lw5_memread", ID_EX_MemRead, 1);
    drive(i_type(6'h04, 5'd5, 5'd0, 16'h0008), C_BEQ, 1'b0, 32'h0, 32'h0, 32'h8, 32'h18);
    chk("h3_first_pc_write", pc_write, 0);
    tick();
    chk("h3_first_bubble", ex_ctrl, 0);
    chk("h3_first_count", stall_cycles, 3);
    #1;
    chk("h3_hold_pc_write", pc_write, 0);
    chk("h3_hold_if_id_write", if_id_write, 0);
    tick();
    chk("h3_second_bubble", ex_ctrl, 0);
    chk("h3_second_count", stall_cycles, 4);
    #1;
    chk("h3_release", pc_write, 1);
    tick();
    chk("h3_beq_ctrl", ex_ctrl, C_BEQ);
    chk("h3_count_hold", stall_cycles, 4);

    // Register $0 never matches
    drive(i_type(6'h23, 5'd3, 5'd0, 16'h0), C_LW, 1'b0, 32'h0, 32'h0, 32'h0, 32'h1C);
    tick();
    chk("lw0_rd", ID_EX_RegisterRd, 0);
    drive(r_type(5'd0, 5'd0, 5'd1), C_ADD, 1'b1, 32'h0, 32'h0, 32'h0, 32'h20);
    chk("r0_pc_write", pc_write, 1);
    tick();
    chk("r0_add_ctrl", ex_ctrl, C_ADD);
    chk("r0_add_rd", ID_EX_RegisterRd, 1);
    chk("r0_count", stall_cycles, 4);

    // Flush during HOLD
    drive(i_type(6'h23, 5'd3, 5'd7, 16'h0), C_LW, 1'b0, 32'h0, 32'h0, 32'h0, 32'h24);
    tick();
    drive(i_type(6'h04, 5'd7, 5'd0, 16'h0002), C_BEQ, 1'b0, 32'h0, 32'h0, 32'h2, 32'h28);
    tick();
    chk("fl_first_count", stall_cycles, 5);
    flush = 1'b1;
    #1;
    chk("fl_pc_write", pc_write, 1);
    chk("fl_if_id_write", if_id_write, 1);
    tick();
    chk("fl_bubble", ex_ctrl, 0);
    chk("fl_no_count", stall_cycles, 5);
    flush = 1'b0;
    #1;
    chk("fl_back_to_run", pc_write, 1);
    tick();
    chk("fl_capture", ex_ctrl, C_BEQ);

    // Reset during HOLD
    drive(i_type(6'h23, 5'd3, 5'd7, 16'h0), C_LW, 1'b0, 32'h55, 32'h66, 32'h0, 32'h2C);
    tick();
    drive(i_type(6'h04, 5'd7, 5'd0, 16'h0002), C_BEQ, 1'b0, 32'h0, 32'h0, 32'h2, 32'h30);
    tick();
    chk("rh_count", stall_cycles, 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rh_count_zero", stall_cycles, 0);
    chk("rh_ctrl_zero", ex_ctrl, 0);
    chk("rh_run_pc_write", pc_write, 1);

    // Saturation via continuous H4 stalls
    ex_mem_memread = 1'b1;
    ex_mem_rd      = 5'd4;
    drive(i_type(6'h04, 5'd4, 5'd0, 16'h0001), C_BEQ, 1'b0, 32'h0, 32'h0, 32'h1, 32'h40);
    chk("h4_pc_write", pc_write, 0);
    for (int i = 0; i < 65535; i++) tick();
    chk("sat_reach", stall_cycles, 16'hFFFF);
    for (int i = 0; i < 3; i++) tick();
    chk("sat_hold", stall_cycles, 16'hFFFF);
    chk("sat_still_stalling", pc_write, 0);
    rst = 1'b1;
    ex_mem_memread = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("sat_rst_count", stall_cycles, 0);
    chk("sat_rst_ctrl", ex_ctrl, 0);
    chk("sat_rst_rs", ID_EX_RegisterRs, 0);
    chk("sat_rst_pc_write", pc_write, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
